// File: rtl/msi_snoop_bus_controller_pkg.sv
// Shared definitions for the dual-core MSI snoop bus controller:
// widths, bus command encodings and controller states.
package msi_bus_pkg;

   localparam int ADDR_BITS    = 11;
   localparam int DATA_BITS    = 8;
   localparam int BLOCK_BYTES  = 2;
   localparam int BLOCK_OFFSET = 1;

   function automatic int blk_w(input int bytes, input int bits);
      return bytes * bits;
   endfunction

   function automatic int ba_w(input int abits, input int off);
      return abits - off;
   endfunction

   localparam int BLK_W = blk_w(BLOCK_BYTES, DATA_BITS);
   localparam int BA_W  = ba_w(ADDR_BITS, BLOCK_OFFSET);

   typedef logic [2:0] cmd_t;

   localparam cmd_t CMD_RD   = 3'b001;
   localparam cmd_t CMD_RDX  = 3'b010;
   localparam cmd_t CMD_UPGR = 3'b011;
   localparam cmd_t CMD_WB   = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SNOOP,
      S_FLUSH,
      S_MEM_RD,
      S_MEM_WR,
      S_DONE
   } state_t;

   // Commands that must be broadcast to the other cache.
   function automatic logic is_snoop_cmd(input cmd_t c);
      return (c == CMD_RD) || (c == CMD_RDX) || (c == CMD_UPGR);
   endfunction

endpackage

// File: rtl/msi_snoop_bus_controller_if.sv
// Bus bundle: two core request/snoop ports plus the memory port.
// master = controller view, slave = cores/memory view.
interface msi_snoop_bus_controller_if;
   import msi_bus_pkg::*;

   logic             req_0,       req_1;
   cmd_t             cmd_0,       cmd_1;
   logic [ADDR_BITS-1:0] addr_0,  addr_1;
   logic [BLK_W-1:0] wdata_0,     wdata_1;
   logic             done_0,      done_1;
   logic [BLK_W-1:0] rdata_0,     rdata_1;
   logic             snp_valid_0, snp_valid_1;
   cmd_t             snp_cmd_0,   snp_cmd_1;
   logic [BA_W-1:0]  snp_addr_0,  snp_addr_1;
   logic             snp_ack_0,   snp_ack_1;
   logic             snp_m_0,     snp_m_1;
   logic [BLK_W-1:0] snp_data_0,  snp_data_1;
   logic             mem_req;
   logic             mem_we;
   logic [BA_W-1:0]  mem_addr;
   logic [BLK_W-1:0] mem_wdata;
   logic [BLK_W-1:0] mem_rdata;
   logic             mem_ready;

   modport master (
      input  req_0, req_1, cmd_0, cmd_1,
      input  addr_0, addr_1, wdata_0, wdata_1,
      output done_0, done_1, rdata_0, rdata_1,
      output snp_valid_0, snp_valid_1,
      output snp_cmd_0, snp_cmd_1,
      output snp_addr_0, snp_addr_1,
      input  snp_ack_0, snp_ack_1,
      input  snp_m_0, snp_m_1,
      input  snp_data_0, snp_data_1,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      output req_0, req_1, cmd_0, cmd_1,
      output addr_0, addr_1, wdata_0, wdata_1,
      input  done_0, done_1, rdata_0, rdata_1,
      input  snp_valid_0, snp_valid_1,
      input  snp_cmd_0, snp_cmd_1,
      input  snp_addr_0, snp_addr_1,
      output snp_ack_0, snp_ack_1,
      output snp_m_0, snp_m_1,
      output snp_data_0, snp_data_1,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );

endinterface

// File: rtl/msi_snoop_bus_controller_rr_arb2.sv
// Two-way round-robin arbiter. Ports: req[1:0] in, update in
// (commit grant), gnt[1:0] out. Core 0 wins the first tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      gnt = req;
      if (req == 2'b11)
         gnt = last_grant ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_grant <= 1'b1;
      else if (update)
         last_grant <= gnt[1];
   end

endmodule

// File: rtl/msi_snoop_bus_controller.sv
// Snoop bus controller: arbitrates two MSI L1 caches, broadcasts
// snoops, completes against memory. Ports: clk, rst, bus (master).
module msi_snoop_bus_controller
   import msi_bus_pkg::*;
(
   input logic                       clk,
   input logic                       rst,
   msi_snoop_bus_controller_if.master bus
);

   state_t           state, state_nx;
   logic             owner;
   cmd_t             cmd_q;
   logic [BA_W-1:0]  baddr_q;
   logic [BLK_W-1:0] wdata_q;
   logic [BLK_W-1:0] blk_q;

   logic [1:0]       req, gnt;
   logic             grant;
   cmd_t             g_cmd;
   logic [BA_W-1:0]  g_baddr;
   logic [BLK_W-1:0] g_wdata;
   logic             s_ack, s_m;
   logic [BLK_W-1:0] s_data;

   assign req   = {bus.req_1, bus.req_0};
   assign grant = (state == S_IDLE) && (|gnt);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .update (grant),
      .gnt    (gnt)
   );

   assign g_cmd   = gnt[1] ? bus.cmd_1 : bus.cmd_0;
   assign g_baddr = gnt[1]
                  ? bus.addr_1[ADDR_BITS-1:BLOCK_OFFSET]
                  : bus.addr_0[ADDR_BITS-1:BLOCK_OFFSET];
   assign g_wdata = gnt[1] ? bus.wdata_1 : bus.wdata_0;

   // Only the non-owner's snoop response counts.
   assign s_ack  = owner ? bus.snp_ack_0  : bus.snp_ack_1;
   assign s_m    = owner ? bus.snp_m_0    : bus.snp_m_1;
   assign s_data = owner ? bus.snp_data_0 : bus.snp_data_1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // blk_q is cleared at grant so UPGR/WB/no-op complete with 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner   <= 1'b0;
         cmd_q   <= '0;
         baddr_q <= '0;
         wdata_q <= '0;
         blk_q   <= '0;
      end else if (grant) begin
         owner   <= gnt[1];
         cmd_q   <= g_cmd;
         baddr_q <= g_baddr;
         wdata_q <= g_wdata;
         blk_q   <= '0;
      end else if (state == S_SNOOP && s_ack && s_m &&
                   cmd_q != CMD_UPGR) begin
         blk_q   <= s_data;
      end else if (state == S_MEM_RD && bus.mem_ready) begin
         blk_q   <= bus.mem_rdata;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (grant) begin
               unique case (1'b1)
                  (g_cmd == CMD_WB):   state_nx = S_MEM_WR;
                  is_snoop_cmd(g_cmd): state_nx = S_SNOOP;
                  default:             state_nx = S_DONE;
               endcase
            end
         end
         S_SNOOP: begin
            if (s_ack) begin
               if (cmd_q == CMD_UPGR)
                  state_nx = S_DONE;
               else if (s_m)
                  state_nx = S_FLUSH;
               else
                  state_nx = S_MEM_RD;
            end
         end
         S_FLUSH, S_MEM_RD, S_MEM_WR: begin
            if (bus.mem_ready)
               state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   logic             done0, done1, sv0, sv1;
   logic             mreq, mwe;
   logic [BLK_W-1:0] mwdata;

   always_comb begin
      done0  = (state == S_DONE)  && !owner;
      done1  = (state == S_DONE)  &&  owner;
      sv0    = (state == S_SNOOP) &&  owner;
      sv1    = (state == S_SNOOP) && !owner;
      mreq   = (state == S_FLUSH) || (state == S_MEM_RD) ||
               (state == S_MEM_WR);
      mwe    = (state == S_FLUSH) || (state == S_MEM_WR);
      mwdata = '0;
      if (state == S_FLUSH)
         mwdata = blk_q;
      else if (state == S_MEM_WR)
         mwdata = wdata_q;
   end

   assign bus.done_0      = done0;
   assign bus.done_1      = done1;
   assign bus.rdata_0     = done0 ? blk_q : '0;
   assign bus.rdata_1     = done1 ? blk_q : '0;
   assign bus.snp_valid_0 = sv0;
   assign bus.snp_valid_1 = sv1;
   assign bus.snp_cmd_0   = sv0 ? cmd_q : '0;
   assign bus.snp_cmd_1   = sv1 ? cmd_q : '0;
   assign bus.snp_addr_0  = sv0 ? baddr_q : '0;
   assign bus.snp_addr_1  = sv1 ? baddr_q : '0;
   assign bus.mem_req     = mreq;
   assign bus.mem_we      = mwe;
   assign bus.mem_addr    = mreq ? baddr_q : '0;
   assign bus.mem_wdata   = mwdata;

endmodule

// File: tb/tb_msi_snoop_bus_controller.sv
// Directed bench for msi_snoop_bus_controller: arbitration, snoop,
// flush, upgrade, writeback, no-op and reset abort.
module tb_msi_snoop_bus_controller;
   import msi_bus_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   msi_snoop_bus_controller_if bus ();

   msi_snoop_bus_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int c, input logic [2:0] cmd,
                        input logic [10:0] a,
                        input logic [15:0] wd);
      if (c == 0) begin
         bus.req_0 = 1'b1; bus.cmd_0 = cmd;
         bus.addr_0 = a;   bus.wdata_0 = wd;
      end else begin
         bus.req_1 = 1'b1; bus.cmd_1 = cmd;
         bus.addr_1 = a;   bus.wdata_1 = wd;
      end
   endtask

   // Called right after the grant edge; plays snooper and memory
   // until the owner's done pulse, recording what it saw.
   task automatic serve(input int c, input logic m,
                        input logic [15:0] sdata,
                        input int lat, input logic [15:0] mrd,
                        output int k_done, output int n_snp,
                        output int n_rd, output int n_wr,
                        output logic [9:0] saddr,
                        output logic [2:0] scmd,
                        output logic [9:0] waddr,
                        output logic [15:0] wdat,
                        output logic [15:0] rdat);
      int   mc;
      logic fin;
      logic sv_own, sv_oth, dn_own, dn_oth;
      k_done = 0; n_snp = 0; n_rd = 0; n_wr = 0;
      saddr = '0; scmd = '0; waddr = '0;
      wdat = '0; rdat = '0; mc = 0; fin = 1'b0;
      for (int k = 1; k <= 30 && !fin; k++) begin
         sv_own = c ? bus.snp_valid_1 : bus.snp_valid_0;
         sv_oth = c ? bus.snp_valid_0 : bus.snp_valid_1;
         dn_own = c ? bus.done_1 : bus.done_0;
         dn_oth = c ? bus.done_0 : bus.done_1;
         chk("owner_snp", {31'b0, sv_own}, 32'd0);
         bus.snp_ack_0 = 1'b0;
         bus.snp_ack_1 = 1'b0;
         if (sv_oth) begin
            n_snp++;
            saddr = c ? bus.snp_addr_0 : bus.snp_addr_1;
            scmd  = c ? bus.snp_cmd_0  : bus.snp_cmd_1;
            if (c == 0) begin
               bus.snp_ack_1 = 1'b1; bus.snp_m_1 = m;
               bus.snp_data_1 = sdata;
            end else begin
               bus.snp_ack_0 = 1'b1; bus.snp_m_0 = m;
               bus.snp_data_0 = sdata;
            end
         end
         bus.mem_ready = 1'b0;
         if (bus.mem_req) begin
            mc++;
            if (bus.mem_we) begin
               n_wr++;
               waddr = bus.mem_addr;
               wdat  = bus.mem_wdata;
            end else begin
               n_rd++;
            end
            bus.mem_ready = (mc > lat);
            bus.mem_rdata = mrd;
         end
         if (dn_own) begin
            fin = 1'b1;
            k_done = k;
            rdat = c ? bus.rdata_1 : bus.rdata_0;
            chk("done_other", {31'b0, dn_oth}, 32'd0);
            if (c == 0) bus.req_0 = 1'b0;
            else        bus.req_1 = 1'b0;
            bus.mem_ready = 1'b0;
            bus.snp_ack_0 = 1'b0;
            bus.snp_ack_1 = 1'b0;
         end else begin
            step();
         end
      end
      chk("done_seen", {31'b0, fin}, 32'd1);
   endtask

   int          k, ns, nr, nw;
   logic [9:0]  sa, wa;
   logic [2:0]  sc;
   logic [15:0] wd, rd;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.req_0 = 0; bus.cmd_0 = 0; bus.addr_0 = 0; bus.wdata_0 = 0;
      bus.req_1 = 0; bus.cmd_1 = 0; bus.addr_1 = 0; bus.wdata_1 = 0;
      bus.snp_ack_0 = 0; bus.snp_m_0 = 0; bus.snp_data_0 = 0;
      bus.snp_ack_1 = 0; bus.snp_m_1 = 0; bus.snp_data_1 = 0;
      bus.mem_rdata = 0; bus.mem_ready = 0;
      step();
      step();
      chk("rst_done0",  {31'b0, bus.done_0},      0);
      chk("rst_done1",  {31'b0, bus.done_1},      0);
      chk("rst_memreq", {31'b0, bus.mem_req},     0);
      chk("rst_snp0",   {31'b0, bus.snp_valid_0}, 0);
      chk("rst_snp1",   {31'b0, bus.snp_valid_1}, 0);
      chk("rst_rdata0", {16'b0, bus.rdata_0},     0);
      rst = 1'b1;
      step();

      // Tie after reset: core 0 first.
      drive(0, CMD_RD, 11'h004, 16'h0);
      drive(1, CMD_RD, 11'h006, 16'h0);
      step();
      serve(0, 0, 0, 0, 16'hA0A0, k, ns, nr, nw, sa, sc, wa, wd, rd);
      chk("tie1_saddr", {22'b0, sa}, 32'h2);
      chk("tie1_rdata", {16'b0, rd}, 32'hA0A0);
      chk("tie1_lat",   k, 3);
      step();
      // Core 0 re-requests against the waiting core 1: core 1 wins.
      drive(0, CMD_RD, 11'h00A, 16'h0);
      step();
      serve(1, 0, 0, 0, 16'hB1B1, k, ns, nr, nw, sa, sc, wa, wd, rd);
      chk("tie2_saddr", {22'b0, sa}, 32'h3);
      chk("tie2_rdata", {16'b0, rd}, 32'hB1B1);
      step();
      step();
      serve(0, 0, 0, 0, 16'hC2C2, k, ns, nr, nw, sa, sc, wa, wd, rd);
      chk("tie3_saddr", {22'b0, sa}, 32'h5);
      chk("tie3_rdata", {16'b0, rd}, 32'hC2C2);
      step();

      // Core 0 read, clean snoop, memory waits 2 cycles.
      drive(0, CMD_RD, 11'h002, 16'h0);
      step();
      serve(0, 0, 0, 2, 16'h1312, k, ns, nr, nw, sa, sc, wa, wd, rd);
      chk("rd_lat",   k, 5);
      chk("rd_nsnp",  ns, 1);
      chk("rd_saddr", {22'b0, sa}, 32'h1);
      chk("rd_scmd",  {29'b0, sc}, 32'h1);
      chk("rd_nrd",   nr, 3);
      chk("rd_nwr",   nw, 0);
      chk("rd_rdata", {16'b0, rd}, 32'h1312);
      step();
      chk("rd_done_drop", {31'b0, bus.done_0}, 0);

      // Core 1 read hits Modified in core 0: flush, no memory read.
      drive(1, CMD_RD, 11'h002, 16'h0);
      step();
      serve(1, 1, 16'h11AB, 0, 16'hDEAD,
            k, ns, nr, nw, sa, sc, wa, wd, rd);
      chk("fl_lat",   k, 3);
      chk("fl_nrd",   nr, 0);
      chk("fl_nwr",   nw, 1);
      chk("fl_waddr", {22'b0, wa}, 32'h1);
      chk("fl_wdata", {16'b0, wd}, 32'h11AB);
      chk("fl_rdata", {16'b0, rd}, 32'h11AB);
      step();

      // Upgrade with immediate ack.
      drive(0, CMD_UPGR, 11'h002, 16'h0);
      step();
      serve(0, 0, 0, 0, 16'h0, k, ns, nr, nw, sa, sc, wa, wd, rd);
      chk("up_lat",   k, 2);
      chk("up_scmd",  {29'b0, sc}, 32'h3);
      chk("up_nmem",  nr + nw, 0);
      chk("up_rdata", {16'b0, rd}, 32'h0);
      step();

      // Writeback, memory waits 1 cycle.
      drive(1, CMD_WB, 11'h008, 16'hBEEF);
      step();
      serve(1, 0, 0, 1, 16'h0, k, ns, nr, nw, sa, sc, wa, wd, rd);
      chk("wb_lat",   k, 3);
      chk("wb_nsnp",  ns, 0);
      chk("wb_nwr",   nw, 2);
      chk("wb_waddr", {22'b0, wa}, 32'h4);
      chk("wb_wdata", {16'b0, wd}, 32'hBEEF);
      chk("wb_rdata", {16'b0, rd}, 32'h0);
      step();

      // Reset abort in MEM_RD with an illegal command pending.
      drive(0, CMD_RD, 11'h010, 16'h0);
      step();
      bus.snp_ack_1 = 1'b1;
      bus.snp_m_1   = 1'b0;
      drive(1, 3'b111, 11'h000, 16'h0);
      step();
      bus.snp_ack_1 = 1'b0;
      chk("ab_memreq_pre", {31'b0, bus.mem_req}, 1);
      rst = 1'b0;
      #1;
      chk("ab_memreq", {31'b0, bus.mem_req},     0);
      chk("ab_done0",  {31'b0, bus.done_0},      0);
      chk("ab_snp1",   {31'b0, bus.snp_valid_1}, 0);
      bus.req_0 = 1'b0;
      #2;
      rst = 1'b1;
      step();
      serve(1, 0, 0, 0, 16'h0, k, ns, nr, nw, sa, sc, wa, wd, rd);
      chk("nop_lat",   k, 1);
      chk("nop_nsnp",  ns, 0);
      chk("nop_nmem",  nr + nw, 0);
      chk("nop_rdata", {16'b0, rd}, 32'h0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
